rst_seq_sr: RTL



---
 rtl/rst_seq_pkg.sv | 26 ++
 rtl/rst_sync_chain.sv | 30 +++
 rtl/rst_seq_sr.sv | 111 +++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_pkg
// Description : Shared types and limits for the rst_seq_sr reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package rst_seq_pkg;

  // Sequencer states; encoding is fixed here so every user agrees on it
  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SWHOLD = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  // Legal synchroniser depth range
  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

  // Hold counter limits: at least one cycle, and the count must fit the counter
  localparam int unsigned HOLD_CYCLES_MIN = 1;
  localparam int unsigned CNT_W_MAX       = 31;

endpackage
`default_nettype wire

// File: rtl/rst_sync_chain.sv
`default_nettype none
// ============================================================================
// Module      : rst_sync_chain
// Description : Async-clear / sync-release flop chain. sync_ok goes high on
//               the STAGES-th rising clk edge after clr_n deasserts.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic clr_n,
  output logic sync_ok
);

  logic [STAGES-1:0] chain;

  // Shift a constant 1 in; clearing is immediate, release walks down the chain
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], 1'b1};
    end
  end

  assign sync_ok = chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rst_seq_sr.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_sr
// Description : Reset sequencer producing a clock-aligned, stretched
//               synchronous active-high reset R, with a four-phase
//               SREQ/SACK handshake for run-time soft resets.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_seq_sr
  import rst_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic C,
  input  logic CLR_N,
  input  logic SREQ,
  output logic R,
  output logic RDY,
  output logic SACK
);

  // Elaboration-time parameter legality checks
  generate
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
      $error("rst_seq_sr: SYNC_STAGES must be in 2..4");
    end
    if (CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
      $error("rst_seq_sr: CNT_W out of range");
    end else if (HOLD_CYCLES < HOLD_CYCLES_MIN ||
                 HOLD_CYCLES > ((32'd1 << CNT_W) - 32'd1)) begin : g_bad_hold
      $error("rst_seq_sr: HOLD_CYCLES does not fit in CNT_W bits");
    end
  endgenerate

  // Counter value on the edge before the hold period completes
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic             sync_ok;
  logic [CNT_W-1:0] cnt;
  state_t           state;

  rst_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (C),
    .clr_n   (CLR_N),
    .sync_ok (sync_ok)
  );

  // Sequencer FSM with hold counter; all outputs registered. The counter is
  // cleared on every state exit so it never wraps.
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      state <= ST_HOLD;
      cnt   <= '0;
      R     <= 1'b1;
      RDY   <= 1'b0;
      SACK  <= 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          // Counting only starts once the release has crossed the synchroniser
          if (sync_ok) begin
            if (cnt == HOLD_LAST) begin
              cnt   <= '0;
              R     <= 1'b0;
              RDY   <= 1'b1;
              state <= ST_RUN;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ST_RUN: begin
          // Level-sensitive: a request already high on entry starts a new pulse
          if (SREQ) begin
            cnt   <= '0;
            R     <= 1'b1;
            RDY   <= 1'b0;
            state <= ST_SWHOLD;
          end
        end
        ST_SWHOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            R     <= 1'b0;
            RDY   <= 1'b1;
            SACK  <= 1'b1;
            state <= ST_ACK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_ACK: begin
          // Wait for the requester to drop SREQ before accepting another
          if (!SREQ) begin
            SACK  <= 1'b0;
            state <= ST_RUN;
          end
        end
        default: begin
          state <= ST_HOLD;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
